// File: rtl/sync_down_timer.sv
// Loadable down-counting timer with start/stop control, one-cycle terminal-count pulse and
// auto-reload. Define SYNC_DOWN_TIMER_CE_EN to add a clock enable gating the count path.
module sync_down_timer #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
`ifdef SYNC_DOWN_TIMER_CE_EN
   input  logic             ce,
`endif
   input  logic             start,
   input  logic             stop,
   input  logic             auto_reload,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             tc
);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   localparam logic [WIDTH-1:0] One = WIDTH'(1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             tc_q, tc_d;
   logic             advance;

`ifdef SYNC_DOWN_TIMER_CE_EN
   assign advance = ce;
`else
   assign advance = 1'b1;
`endif

   // Priority stop > start > count. In RUN the count is never 0, so the
   // terminal branch is only reached at count == 1.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      tc_d     = 1'b0;
      if (stop) begin
         state_d = StIdle;
         count_d = '0;
      end else if (start) begin
         if (load_val == '0) begin
            state_d = StIdle;
            count_d = '0;
            tc_d    = 1'b1;
         end else begin
            state_d  = StRun;
            count_d  = load_val;
            reload_d = load_val;
         end
      end else if ((state_q == StRun) && advance) begin
         if (count_q > One) begin
            count_d = count_q - One;
         end else begin
            tc_d = 1'b1;
            if (auto_reload) begin
               count_d = reload_q;
            end else begin
               count_d = '0;
               state_d = StIdle;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         count_q  <= '0;
         reload_q <= '0;
         tc_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         tc_q     <= tc_d;
      end
   end

   assign count = count_q;
   assign busy  = (state_q == StRun);
   assign tc    = tc_q;

endmodule

// File: tb/tb_sync_down_timer.sv
// Self-checking bench for sync_down_timer: directed scenarios then random commands, checked
// every cycle against a start-time/elapsed-cycle model of the timer.
module tb_sync_down_timer;

   localparam int unsigned WIDTH = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             ce;
   logic             start;
   logic             stop;
   logic             auto_reload;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             tc;

   int unsigned total  = 0;
   int unsigned passed = 0;

   // Model: a run is described by its length N and cycles elapsed since (re)load.
   bit m_active;
   int m_n;
   int m_elapsed;
   bit m_tc;

   always #5 clk = ~clk;

   sync_down_timer #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst         (rst),
`ifdef SYNC_DOWN_TIMER_CE_EN
      .ce          (ce),
`endif
      .start       (start),
      .stop        (stop),
      .auto_reload (auto_reload),
      .load_val    (load_val),
      .count       (count),
      .busy        (busy),
      .tc          (tc)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   function automatic int exp_count();
      return m_active ? (m_n - m_elapsed) : 0;
   endfunction

   task automatic model_reset();
      m_active  = 1'b0;
      m_n       = 0;
      m_elapsed = 0;
      m_tc      = 1'b0;
   endtask

   task automatic model_edge(input bit st, input bit sp, input bit ar, input int lv,
                             input bit c);
      m_tc = 1'b0;
      if (sp) begin
         m_active = 1'b0;
      end else if (st) begin
         if (lv == 0) begin
            m_active = 1'b0;
            m_tc     = 1'b1;
         end else begin
            m_active  = 1'b1;
            m_n       = lv;
            m_elapsed = 0;
         end
      end else if (m_active && c) begin
         m_elapsed++;
         if (m_elapsed == m_n) begin
            m_tc = 1'b1;
            if (ar) m_elapsed = 0;
            else m_active = 1'b0;
         end
      end
   endtask

   // Drive one cycle of inputs, advance the model at the edge, compare 1 time unit later.
   task automatic step(input bit st, input bit sp, input bit ar, input int lv, input bit c);
      start       = st;
      stop        = sp;
      auto_reload = ar;
      load_val    = lv[WIDTH-1:0];
      ce          = c;
      @(posedge clk);
      model_edge(st, sp, ar, lv, c);
      #1;
      check("count", 32'(count), 32'(exp_count()));
      check("busy", 32'(busy), 32'(m_active));
      check("tc", 32'(tc), 32'(m_tc));
      start = 1'b0;
      stop  = 1'b0;
   endtask

   initial begin
      int  lat;
      bit  seen;
      bit  ar_r;
      bit  st_r;
      bit  sp_r;
      bit  ce_r;
      int  lv_r;

      rst         = 1'b1;
      start       = 1'b0;
      stop        = 1'b0;
      auto_reload = 1'b0;
      load_val    = '0;
      ce          = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_count", 32'(count), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_tc", 32'(tc), 32'd0);
      rst = 1'b0;

      // Asynchronous reset mid-run at count 5
      step(1, 0, 0, 5, 1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_count", 32'(count), 32'd0);
      check("async_rst_busy", 32'(busy), 32'd0);
      check("async_rst_tc", 32'(tc), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      repeat (3) step(0, 0, 0, 0, 1);

      // One-shot 3
      step(1, 0, 0, 3, 1);
      repeat (4) step(0, 0, 0, 0, 1);

      // Auto-reload 4, then drop auto_reload
      step(1, 0, 1, 4, 1);
      repeat (9) step(0, 0, 1, 0, 1);
      repeat (5) step(0, 0, 0, 0, 1);

      // Auto-reload with reload value 1: tc every cycle
      step(1, 0, 1, 1, 1);
      repeat (4) step(0, 0, 1, 0, 1);
      step(0, 1, 1, 0, 1);

      // Stop after 2 cycles, then start+stop together
      step(1, 0, 0, 9, 1);
      repeat (2) step(0, 0, 0, 0, 1);
      step(0, 1, 0, 0, 1);
      step(1, 1, 0, 7, 1);
      step(0, 0, 0, 0, 1);
      step(1, 0, 0, 7, 1);
      step(1, 1, 0, 3, 1);
      step(0, 0, 0, 0, 1);

      // Zero-length timeout, in IDLE and as a restart from RUN
      step(1, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      step(1, 0, 0, 6, 1);
      step(1, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);

      // Maximum load: tc exactly 15 cycles after start
      step(1, 0, 0, 15, 1);
      lat  = 0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         step(0, 0, 0, 0, 1);
         lat++;
         seen = tc;
      end
      check("max_load_latency", 32'(lat), 32'd15);

      // Restart mid-run with 2
      step(1, 0, 0, 9, 1);
      repeat (3) step(0, 0, 0, 0, 1);
      step(1, 0, 0, 2, 1);
      repeat (3) step(0, 0, 0, 0, 1);

`ifdef SYNC_DOWN_TIMER_CE_EN
      // ce high every 3rd cycle, load 2: tc 6 clocks after start, one clock wide
      step(1, 0, 0, 2, 0);
      lat  = 0;
      seen = 1'b0;
      for (int i = 1; i <= 10 && !seen; i++) begin
         step(0, 0, 0, 0, (i % 3) == 0);
         lat++;
         seen = tc;
      end
      check("ce_latency", 32'(lat), 32'd6);
      step(0, 0, 0, 0, 0);
`endif

      // Random commands
      ar_r = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 31) == 0) ar_r = ~ar_r;
         st_r = ($urandom_range(0, 9) == 0);
         sp_r = ($urandom_range(0, 24) == 0);
         lv_r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2))
                                            : int'($urandom_range(0, 15));
`ifdef SYNC_DOWN_TIMER_CE_EN
         ce_r = ($urandom_range(0, 2) != 0);
`else
         ce_r = 1'b1;
`endif
         step(st_r, sp_r, ar_r, lv_r, ce_r);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
